// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, non-pipelined memory between the insn-fetch port
// and the data (load/store) port. One transaction is in flight at a time. The data port has
// fixed priority, and a saturating starvation counter forces an insn grant after STARVE_MAX
// consecutive contested data grants. All outputs are registered.
//
// Ports:
//   clk, _reset               clock (rising edge), asynchronous active-low reset
//   i_req/i_addr              insn read request, held until i_ack
//   i_ack/i_rdata             insn completion pulse, read data (held until next insn read)
//   d_req/d_rw/d_addr/d_wdata data request (d_rw=1 write), held until d_ack
//   d_ack/d_rdata             data completion pulse, read data (held until next data read)
//   m_en/m_rw/m_addr/m_wdata  memory strobe (one cycle per access) and access fields
//   m_rdata                   memory read data, valid LATENCY cycles after the strobe
//   busy                      high whenever the arbiter is not idle
//   owner                     port owning the current transaction (0=insn, 1=data)
module mem_arbiter #(
    parameter int unsigned LATENCY    = 1,
    parameter int unsigned STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        _reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_rw,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        owner
);

    localparam logic [2:0] LatCnt    = 3'(LATENCY);
    localparam logic [2:0] StarveMax = 3'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

    state_e      state_q, state_d;
    logic [2:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]  starve_cnt_q, starve_cnt_d;
    logic        i_ack_d, d_ack_d, m_en_d, m_rw_d, busy_d, owner_d;
    logic [31:0] i_rdata_d, d_rdata_d, m_addr_d, m_wdata_d;
    logic        d_wins;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q      <= StIdle;
            wait_cnt_q   <= '0;
            starve_cnt_q <= '0;
            i_ack        <= 1'b0;
            d_ack        <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            m_en         <= 1'b0;
            m_rw         <= 1'b0;
            m_addr       <= '0;
            m_wdata      <= '0;
            busy         <= 1'b0;
            owner        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            i_ack        <= i_ack_d;
            d_ack        <= d_ack_d;
            i_rdata      <= i_rdata_d;
            d_rdata      <= d_rdata_d;
            m_en         <= m_en_d;
            m_rw         <= m_rw_d;
            m_addr       <= m_addr_d;
            m_wdata      <= m_wdata_d;
            busy         <= busy_d;
            owner        <= owner_d;
        end
    end

    // Outputs are computed as next-state values so every output leaves a flop.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        starve_cnt_d = starve_cnt_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_rdata_d    = i_rdata;
        d_rdata_d    = d_rdata;
        m_en_d       = 1'b0;
        m_rw_d       = m_rw;
        m_addr_d     = m_addr;
        m_wdata_d    = m_wdata;
        owner_d      = owner;
        // Data wins unless the insn port has been passed over STARVE_MAX times in a row.
        d_wins       = d_req && !(i_req && (starve_cnt_q == StarveMax));

        case (state_q)
            StIdle: begin
                if (d_wins) begin
                    state_d   = StIssue;
                    owner_d   = 1'b1;
                    m_en_d    = 1'b1;
                    m_rw_d    = d_rw;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    // A contested data grant implies starve_cnt_q < StarveMax, so no overflow.
                    if (i_req) begin
                        starve_cnt_d = starve_cnt_q + 3'd1;
                    end
                end else if (i_req) begin
                    state_d      = StIssue;
                    owner_d      = 1'b0;
                    m_en_d       = 1'b1;
                    m_rw_d       = 1'b0;
                    m_addr_d     = i_addr;
                    starve_cnt_d = '0;
                end
            end
            StIssue: begin
                if (m_rw) begin
                    state_d = StAck;
                    d_ack_d = 1'b1;
                end else begin
                    state_d    = StWait;
                    wait_cnt_d = 3'd1;
                end
            end
            StWait: begin
                // wait_cnt_q counts cycles since ISSUE; m_rdata is valid when it hits LATENCY.
                if (wait_cnt_q == LatCnt) begin
                    state_d = StAck;
                    if (owner) begin
                        d_rdata_d = m_rdata;
                        d_ack_d   = 1'b1;
                    end else begin
                        i_rdata_d = m_rdata;
                        i_ack_d   = 1'b1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 3'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: self-checking bench for mem_arbiter. One instance runs with LATENCY=1 and a
// second with LATENCY=3. A behavioural memory drives m_rdata with valid data only in the cycle
// LATENCY cycles after the strobe. Read results are checked through per-port queues filled
// when a request is driven and drained when the matching ack appears.
module tb_mem_arbiter;

    localparam int unsigned L1  = 1;
    localparam int unsigned L3  = 3;
    localparam logic [31:0] Bad = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // LATENCY=1 instance
    logic        i_req = 1'b0, i_ack, d_req = 1'b0, d_rw = 1'b0, d_ack;
    logic [31:0] i_addr = '0, i_rdata, d_addr = '0, d_wdata = '0, d_rdata;
    logic        m_en, m_rw, busy, owner;
    logic [31:0] m_addr, m_wdata, m_rdata = Bad;

    // LATENCY=3 instance
    logic        x_i_req = 1'b0, x_i_ack, x_d_req = 1'b0, x_d_rw = 1'b0, x_d_ack;
    logic [31:0] x_i_addr = '0, x_i_rdata, x_d_addr = '0, x_d_wdata = '0, x_d_rdata;
    logic        x_m_en, x_m_rw, x_busy, x_owner;
    logic [31:0] x_m_addr, x_m_wdata, x_m_rdata = Bad;

    mem_arbiter #(.LATENCY(L1), .STARVE_MAX(2)) dut (
        .clk(clk), ._reset(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .busy(busy), .owner(owner)
    );

    mem_arbiter #(.LATENCY(L3), .STARVE_MAX(2)) dut3 (
        .clk(clk), ._reset(rst_n),
        .i_req(x_i_req), .i_addr(x_i_addr), .i_ack(x_i_ack), .i_rdata(x_i_rdata),
        .d_req(x_d_req), .d_rw(x_d_rw), .d_addr(x_d_addr), .d_wdata(x_d_wdata),
        .d_ack(x_d_ack), .d_rdata(x_d_rdata),
        .m_en(x_m_en), .m_rw(x_m_rw), .m_addr(x_m_addr), .m_wdata(x_m_wdata),
        .m_rdata(x_m_rdata), .busy(x_busy), .owner(x_owner)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b", name, got, exp);
        end
    endtask

    // ---------------- behavioural memory ----------------
    logic [31:0] wdat [64];
    logic [31:0] wtag [64];
    logic        wval [64] = '{default: 1'b0};

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (wval[a[7:2]] && wtag[a[7:2]] == a) return wdat[a[7:2]];
        case (a)
            32'h0000_1000: return 32'hDEAD_BEEF;
            32'h0000_0040: return 32'hCAFE_F00D;
            default:       return ~a;
        endcase
    endfunction

    int unsigned mcnt = 0, xmcnt = 0;
    logic [31:0] maddr = '0, xmaddr = '0;

    always @(posedge clk) begin
        if (m_en && m_rw) begin
            wdat[m_addr[7:2]] <= m_wdata;
            wtag[m_addr[7:2]] <= m_addr;
            wval[m_addr[7:2]] <= 1'b1;
        end
        if (m_en && !m_rw) begin
            mcnt    <= 1;
            maddr   <= m_addr;
            m_rdata <= (L1 == 1) ? memrd(m_addr) : Bad;
        end else if (mcnt != 0) begin
            mcnt    <= mcnt + 1;
            m_rdata <= (mcnt + 1 == L1) ? memrd(maddr) : Bad;
        end
    end

    always @(posedge clk) begin
        if (x_m_en && !x_m_rw) begin
            xmcnt     <= 1;
            xmaddr    <= x_m_addr;
            x_m_rdata <= (L3 == 1) ? memrd(x_m_addr) : Bad;
        end else if (xmcnt != 0) begin
            xmcnt     <= xmcnt + 1;
            x_m_rdata <= (xmcnt + 1 == L3) ? memrd(xmaddr) : Bad;
        end
    end

    // ---------------- scoreboard ----------------
    logic [31:0] i_q[$];
    logic [31:0] d_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (i_ack) begin
                if (i_q.size() == 0) check1("spurious_i_ack", i_ack, 1'b0);
                else check("sb_i_rdata", i_rdata, i_q.pop_front());
            end
            if (d_ack) begin
                if (d_q.size() == 0) check1("spurious_d_ack", d_ack, 1'b0);
                else check("sb_d_rdata", d_rdata, d_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic        port;      // 0=insn, 1=data
        logic        rw;        // 1=write
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t        tbl[8];
    logic [31:0] i_hold = '0;
    logic [31:0] d_hold = '0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one lone transaction starting in an IDLE cycle (cycle 0) and checks its timing.
    task automatic run_txn(input vec_t v);
        int   n;
        logic got;
        if (v.port) begin
            d_req = 1'b1; d_rw = v.rw; d_addr = v.addr; d_wdata = v.wdata;
            d_q.push_back(v.rw ? d_hold : v.exp_rdata);
        end else begin
            i_req = 1'b1; i_addr = v.addr;
            i_q.push_back(v.exp_rdata);
        end
        step();
        check1("issue_m_en", m_en, 1'b1);
        check1("issue_m_rw", m_rw, v.rw);
        check("issue_m_addr", m_addr, v.addr);
        if (v.rw) check("issue_m_wdata", m_wdata, v.wdata);
        check1("issue_owner", owner, v.port);
        check1("issue_busy", busy, 1'b1);
        n   = 1;
        got = 1'b0;
        while (!got && n < 20) begin
            step();
            n++;
            got = v.port ? d_ack : i_ack;
            check1("m_en_once", m_en, 1'b0);
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check("ack_cycle", n, v.rw ? 2 : 2 + L1);
        if (!v.rw) begin
            if (v.port) d_hold = v.exp_rdata;
            else        i_hold = v.exp_rdata;
        end
        check("i_rdata_hold", i_rdata, i_hold);
        check("d_rdata_hold", d_rdata, d_hold);
        step();
        check1("idle_busy", busy, 1'b0);
        check1("ack_one_cycle", v.port ? d_ack : i_ack, 1'b0);
    endtask

    logic exp_seq[6];
    logic gseq[6];
    int   grants, acks, first_ack, second_ack;

    initial begin
        tbl[0] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0,          32'hDEAD_BEEF};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678,  32'h0};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,          32'h1234_5678};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0020, 32'h0,          32'h1234_5678};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_1004, 32'hA5A5_5A5A,  32'h0};
        tbl[5] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0,          32'hA5A5_5A5A};
        tbl[6] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,          32'hDEAD_BEEF};
        tbl[7] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0,          32'hFFFF_FCFF};
        exp_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        gseq    = '{default: 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_m_en", m_en, 1'b0);
        check("rst_m_addr", m_addr, 32'h0);
        check1("rst_owner", owner, 1'b0);
        check1("rst_x_busy", x_busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Lone transactions
        for (int k = 0; k < 8; k++) run_txn(tbl[k]);

        // Both ports requesting continuously: expect D,D,I,D,D,I
        i_req = 1'b1; i_addr = 32'h0000_1000;
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h0000_0020;
        i_q.push_back(32'hDEAD_BEEF);
        d_q.push_back(32'h1234_5678);
        grants = 0;
        acks   = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (m_en && grants < 6) begin
                gseq[grants] = owner;
                grants++;
            end
            if (i_ack || d_ack) begin
                acks++;
                if (acks == 6) begin
                    i_req = 1'b0;
                    d_req = 1'b0;
                    break;
                end
                if (i_ack) i_q.push_back(32'hDEAD_BEEF);
                if (d_ack) d_q.push_back(32'h1234_5678);
            end
        end
        check("contend_acks", acks, 6);
        for (int k = 0; k < 6; k++) check1($sformatf("grant_%0d", k), gseq[k], exp_seq[k]);
        repeat (3) step();
        check1("contend_idle", busy, 1'b0);
        i_q.delete();
        d_q.delete();
        i_hold = 32'hDEAD_BEEF;
        d_hold = 32'h1234_5678;

        // Reset in WAIT of an insn read
        i_req = 1'b1; i_addr = 32'h0000_1004;
        step();
        check1("prerst_issue", m_en, 1'b1);
        step();
        check1("prerst_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        i_req = 1'b0;
        #1;
        check1("midrst_i_ack", i_ack, 1'b0);
        check1("midrst_d_ack", d_ack, 1'b0);
        check("midrst_i_rdata", i_rdata, 32'h0);
        check("midrst_d_rdata", d_rdata, 32'h0);
        check1("midrst_m_en", m_en, 1'b0);
        check1("midrst_m_rw", m_rw, 1'b0);
        check("midrst_m_addr", m_addr, 32'h0);
        check("midrst_m_wdata", m_wdata, 32'h0);
        check1("midrst_busy", busy, 1'b0);
        check1("midrst_owner", owner, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        i_hold = 32'h0;
        d_hold = 32'h0;
        for (int c = 0; c < 4; c++) begin
            step();
            check1("postrst_no_ack", i_ack, 1'b0);
        end
        run_txn(tbl[0]);

        // i_req held through i_ack: acks in cycles 3 and 7
        i_req = 1'b1; i_addr = 32'h0000_1004;
        i_q.push_back(32'hA5A5_5A5A);
        i_q.push_back(32'hA5A5_5A5A);
        first_ack  = 0;
        second_ack = 0;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (c == 4) check1("held_idle", busy, 1'b0);
            if (c == 5) check1("held_issue2", m_en, 1'b1);
            if (i_ack) begin
                if (first_ack == 0) first_ack = c;
                else begin
                    second_ack = c;
                    i_req = 1'b0;
                end
            end
        end
        check("held_ack1_cycle", first_ack, 3);
        check("held_ack2_cycle", second_ack, 7);

        // LATENCY=3 data read
        x_d_req = 1'b1; x_d_rw = 1'b0; x_d_addr = 32'h0000_0040;
        for (int c = 1; c <= 6; c++) begin
            step();
            check1($sformatf("l3_m_en_c%0d", c), x_m_en, c == 1);
            check1($sformatf("l3_busy_c%0d", c), x_busy, c <= 5);
            check1($sformatf("l3_d_ack_c%0d", c), x_d_ack, c == 5);
            if (c == 5) begin
                check("l3_d_rdata", x_d_rdata, 32'hCAFE_F00D);
                x_d_req = 1'b0;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
